traffic_sensor_conditioner: RTL and testbench

Conditions the two raw vehicle-detector inputs before they reach the two-road traffic-light controller, which is the directly downstream stage. Each raw input is asynchronous and bouncy. The block synchronizes and debounces each one, and extends presence by a hold window so the controller sees clean, glitch-free TA/TB flags. It also keeps a saturating vehicle count per direction for the status display.

---
 rtl/traffic_sensor_conditioner.sv | 137 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Vehicle-detector conditioning: each raw input is synchronized, debounced and
// stretched by a hold window into a clean presence flag, with a saturating arrival count.

module traffic_sensor_channel #(
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   raw,
  input  logic                   clear_counts,
  output logic                   present,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int TMAX = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ARM     = 5'b00010,
    PRESENT = 5'b00100,
    RELEASE = 5'b01000,
    HOLD_ST = 5'b10000
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   present_q, present_d;
  logic                   inc;
  logic                   s;

  assign s = sync_q[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    timer_d = timer_q;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: if (s) begin
        state_d = ARM;
        timer_d = '0;
      end
      ARM: begin
        if (!s)                        state_d = IDLE;
        else if (timer_q == DEB_LAST) begin
          state_d = PRESENT;
          inc     = 1'b1;
        end else                       timer_d = timer_q + 1'b1;
      end
      PRESENT: if (!s) begin
        state_d = RELEASE;
        timer_d = '0;
      end
      RELEASE: begin
        if (s)                         state_d = PRESENT;
        else if (timer_q == DEB_LAST) begin
          state_d = HOLD_ST;
          timer_d = '0;
        end else                       timer_d = timer_q + 1'b1;
      end
      HOLD_ST: begin
        // Return within the hold window is the same platoon: no new count.
        if (s)                         state_d = PRESENT;
        else if (timer_q == HOLD_LAST) state_d = IDLE;
        else                           timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    present_d = (state_d == PRESENT) || (state_d == RELEASE) || (state_d == HOLD_ST);

    count_d = count_q;
    if (clear_counts)                count_d = '0;
    else if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      present_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      present_q <= present_d;
    end
  end

  assign present = present_q;
  assign count   = count_q;

endmodule

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   raw_a,
  input  logic                   raw_b,
  input  logic                   clear_counts,
  output logic                   TA,
  output logic                   TB,
  output logic [COUNT_WIDTH-1:0] count_a,
  output logic [COUNT_WIDTH-1:0] count_b
);

  traffic_sensor_channel #(
    .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .COUNT_WIDTH(COUNT_WIDTH)
  ) u_chan_a (
    .clock(clock), .reset(reset), .raw(raw_a), .clear_counts(clear_counts),
    .present(TA), .count(count_a)
  );

  traffic_sensor_channel #(
    .DEBOUNCE(DEBOUNCE), .HOLD(HOLD), .COUNT_WIDTH(COUNT_WIDTH)
  ) u_chan_b (
    .clock(clock), .reset(reset), .raw(raw_b), .clear_counts(clear_counts),
    .present(TB), .count(count_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: default instance plus a
// COUNT_WIDTH=2 instance for saturation and clear-versus-increment.

module tb_traffic_sensor_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       raw_a = 1'b0, raw_b = 1'b0, clear_counts = 1'b0;
  logic       TA, TB;
  logic [7:0] count_a, count_b;

  logic       raw_a2 = 1'b0, raw_b2 = 1'b0, clear2 = 1'b0;
  logic       TA2, TB2;
  logic [1:0] count_a2, count_b2;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clock = ~clock;

  traffic_sensor_conditioner dut (
    .clock(clock), .reset(reset), .raw_a(raw_a), .raw_b(raw_b),
    .clear_counts(clear_counts), .TA(TA), .TB(TB),
    .count_a(count_a), .count_b(count_b)
  );

  traffic_sensor_conditioner #(.COUNT_WIDTH(2)) dut_w2 (
    .clock(clock), .reset(reset), .raw_a(raw_a2), .raw_b(raw_b2),
    .clear_counts(clear2), .TA(TA2), .TB(TB2),
    .count_a(count_a2), .count_b(count_b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One full debounced arrival and departure on the narrow instance, channel B.
  task automatic w2_vehicle(input logic [1:0] exp_count, input string tag);
    raw_b2 = 1'b1;
    tick(7);
    check({tag, "_tb"}, TB2, 1);
    check({tag, "_count"}, count_b2, exp_count);
    raw_b2 = 1'b0;
    tick(17);
    check({tag, "_tb_off"}, TB2, 0);
  endtask

  initial begin
    // 1. Reset state and first arrival on A.
    tick(2);
    reset = 1'b0;
    tick();
    check("rst_ta", TA, 0);
    check("rst_tb", TB, 0);
    check("rst_count_a", count_a, 0);
    check("rst_count_b", count_b, 0);
    raw_a = 1'b1;
    tick(6);
    check("arr_ta_edge6", TA, 0);
    check("arr_count_edge6", count_a, 0);
    tick();
    check("arr_ta_edge7", TA, 1);
    check("arr_count_a", count_a, 1);
    check("arr_tb", TB, 0);
    check("arr_count_b", count_b, 0);

    // 3a. Departure: TA held through edge 14, low after edge 15.
    raw_a = 1'b0;
    tick(14);
    check("dep_ta_edge14", TA, 1);
    tick();
    check("dep_ta_edge15", TA, 0);
    tick(3);

    // 2. Short pulses are rejected (3 and 4 cycles).
    seen = 1'b0;
    raw_a = 1'b1;
    tick(3);
    raw_a = 1'b0;
    repeat (10) begin tick(); seen |= TA; end
    check("pulse3_ta", seen, 0);
    check("pulse3_count", count_a, 1);
    raw_a = 1'b1;
    tick(4);
    raw_a = 1'b0;
    repeat (10) begin tick(); seen |= TA; end
    check("pulse4_ta", seen, 0);
    check("pulse4_count", count_a, 1);

    // 3b. Arrival, then a 2-cycle dropout during PRESENT never drops TA.
    raw_a = 1'b1;
    tick(7);
    check("arr2_ta", TA, 1);
    check("arr2_count", count_a, 2);
    seen = 1'b1;
    raw_a = 1'b0;
    tick(2);
    seen &= TA;
    raw_a = 1'b1;
    repeat (10) begin tick(); seen &= TA; end
    check("dropout_ta", seen, 1);
    check("dropout_count", count_a, 2);

    // 4. Return during HOLD keeps TA and does not count.
    raw_a = 1'b0;
    tick(9);
    check("hold_ta", TA, 1);
    raw_a = 1'b1;
    repeat (8) begin tick(); seen &= TA; end
    check("hold_return_ta", seen, 1);
    check("hold_return_count", count_a, 2);
    raw_a = 1'b0;
    tick(14);
    check("expire_ta_edge14", TA, 1);
    tick();
    check("expire_ta_edge15", TA, 0);
    tick(3);
    raw_a = 1'b1;
    tick(7);
    check("fresh_ta", TA, 1);
    check("fresh_count", count_a, 3);

    // 5. Saturation at 3 on a 2-bit counter, then clear beats a same-edge increment.
    w2_vehicle(2'd1, "sat1");
    w2_vehicle(2'd2, "sat2");
    w2_vehicle(2'd3, "sat3");
    w2_vehicle(2'd3, "sat4");
    w2_vehicle(2'd3, "sat5");
    raw_b2 = 1'b1;
    tick(6);
    check("clr_pre_count", count_b2, 3);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    check("clr_count", count_b2, 0);
    check("clr_tb_unaffected", TB2, 1);
    tick();
    check("clr_count_hold", count_b2, 0);
    check("w2_chan_a_idle", count_a2, 0);

    // 6. Reset mid-operation: A in RELEASE, B in ARM.
    raw_a = 1'b0;
    raw_b = 1'b1;
    tick(4);
    check("pre_rst_ta", TA, 1);
    check("pre_rst_tb", TB, 0);
    raw_a = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ta", TA, 0);
    check("midrst_tb", TB, 0);
    check("midrst_count_a", count_a, 0);
    check("midrst_count_b", count_b, 0);
    tick(6);
    check("rearm_ta_edge6", TA, 0);
    check("rearm_tb_edge6", TB, 0);
    tick();
    check("rearm_ta_edge7", TA, 1);
    check("rearm_tb_edge7", TB, 1);
    check("rearm_count_a", count_a, 1);
    check("rearm_count_b", count_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
